// File: rtl/rvecc_scrubber.sv
// Background SECDED scrubber: walks every address, corrects single-bit errors in place, reports double-bit errors.
// Latency: with an immediate grant and rvalid one cycle later, a clean word takes 4 cycles (RD_REQ to IDLE) and a corrected word takes 5.
// Backpressure: mem_req and its address, write enable and data hold until mem_gnt. Only one transfer is ever outstanding.
// Ports: clk/rst_l (async, active low); scrub_en, cnt_clr (control);
//        mem_req/mem_we/mem_addr/mem_wdata/mem_gnt/mem_rvalid/mem_rdata (memory port);
//        sec_cnt/ded_cnt (saturating counts); ded_valid/ded_addr (double error report); pass_done (wrap pulse).
module rvecc_scrubber #(
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 10,
  parameter int INTERVAL = 256
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              scrub_en,
  input  logic              cnt_clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [38:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [38:0]       mem_rdata,
  output logic [15:0]       sec_cnt,
  output logic [15:0]       ded_cnt,
  output logic              ded_valid,
  output logic [ADDR_W-1:0] ded_addr,
  output logic              pass_done
);

  typedef struct packed {
    logic [6:0]  ecc;
    logic [31:0] data;
  } cw_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_WR_REQ  = 3'd4;
  localparam logic [2:0] ST_NEXT    = 3'd5;

  localparam int               CNT_W     = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CNT_W-1:0] IVL_LAST  = CNT_W'(INTERVAL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  // Hamming position of data bit idx: data occupies the non-power-of-two
  // positions 3,5,6,7,9,...,38; check bit j covers positions with bit j set.
  function automatic logic [5:0] hpos(input int idx);
    logic [5:0] r;
    int         n;
    r = '0;
    n = 0;
    for (int c = 3; c < 64; c++) begin
      if ((c & (c - 1)) != 0) begin
        if (n == idx) r = 6'(c);
        n++;
      end
    end
    return r;
  endfunction

  // Check bits for a data word; ecc[6] makes the whole 39-bit codeword even parity.
  function automatic logic [6:0] rvecc_encode(input logic [31:0] data);
    logic [5:0] chk;
    logic [5:0] pos;
    chk = '0;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 32; i++) begin
        pos = hpos(i);
        if (pos[j]) chk[j] = chk[j] ^ data[i];
      end
    end
    return {^{chk, data}, chk};
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  ivl_q, ivl_d;
  cw_t               rdata_q, rdata_d;
  cw_t               wdata_q, wdata_d;
  logic [15:0]       sec_cnt_q, sec_cnt_d;
  logic [15:0]       ded_cnt_q, ded_cnt_d;
  logic [ADDR_W-1:0] ded_addr_q, ded_addr_d;

  // Decoder on the registered read word, only active in CHECK.
  logic        dec_en;
  logic [5:0]  dec_syn;
  logic [5:0]  dec_pos;
  logic        dec_par;
  logic [31:0] dec_dout;
  logic        dec_single;
  logic        dec_double;

  always_comb begin
    dec_en     = (state_q == ST_CHECK);
    dec_syn    = rdata_q.ecc[5:0];
    dec_pos    = '0;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 32; i++) begin
        dec_pos = hpos(i);
        if (dec_pos[j]) dec_syn[j] = dec_syn[j] ^ rdata_q.data[i];
      end
    end
    dec_par    = ^rdata_q;
    dec_dout   = rdata_q.data;
    dec_single = 1'b0;
    dec_double = 1'b0;
    if (dec_en) begin
      if (dec_par) begin
        // Odd parity with a syndrome pointing past bit 38 cannot be one flip.
        if (dec_syn > 6'd38) begin
          dec_double = 1'b1;
        end else begin
          dec_single = 1'b1;
          for (int i = 0; i < 32; i++) begin
            dec_pos = hpos(i);
            if (dec_syn == dec_pos) dec_dout[i] = ~rdata_q.data[i];
          end
        end
      end else if (dec_syn != 6'd0) begin
        dec_double = 1'b1;
      end
    end
  end

  logic sec_inc;
  logic ded_inc;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ivl_d      = ivl_q;
    rdata_d    = rdata_q;
    wdata_d    = wdata_q;
    sec_cnt_d  = sec_cnt_q;
    ded_cnt_d  = ded_cnt_q;
    ded_addr_d = ded_addr_q;
    sec_inc    = 1'b0;
    ded_inc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (scrub_en) begin
          if (ivl_q == IVL_LAST) begin
            ivl_d   = '0;
            state_d = ST_RD_REQ;
          end else begin
            ivl_d = ivl_q + CNT_W'(1);
          end
        end
      end
      ST_RD_REQ: begin
        if (mem_gnt) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (dec_single) begin
          sec_inc = 1'b1;
          // Check bits are regenerated from the corrected data; this also
          // repairs a flipped check bit.
          wdata_d = {rvecc_encode(dec_dout), dec_dout};
          state_d = ST_WR_REQ;
        end else if (dec_double) begin
          ded_inc    = 1'b1;
          ded_addr_d = addr_q;
          state_d    = ST_NEXT;
        end else begin
          state_d = ST_NEXT;
        end
      end
      ST_WR_REQ: begin
        if (mem_gnt) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        addr_d  = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A clear in the same cycle as an increment wins.
    if (cnt_clr) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else begin
      if (sec_inc && (sec_cnt_q != 16'hFFFF)) sec_cnt_d = sec_cnt_q + 16'd1;
      if (ded_inc && (ded_cnt_q != 16'hFFFF)) ded_cnt_d = ded_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      ivl_q      <= '0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      sec_cnt_q  <= '0;
      ded_cnt_q  <= '0;
      ded_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ivl_q      <= ivl_d;
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
      sec_cnt_q  <= sec_cnt_d;
      ded_cnt_q  <= ded_cnt_d;
      ded_addr_q <= ded_addr_d;
    end
  end

  assign mem_req   = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
  assign mem_we    = (state_q == ST_WR_REQ);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign sec_cnt   = sec_cnt_q;
  assign ded_cnt   = ded_cnt_q;
  assign ded_valid = ded_inc;
  // Present the failing address during the pulse itself, then hold it.
  assign ded_addr  = ded_inc ? addr_q : ded_addr_q;
  assign pass_done = (state_q == ST_NEXT) && (addr_q == ADDR_LAST);

endmodule

// File: tb/tb_rvecc_scrubber.sv
// Scoreboard bench for rvecc_scrubber with a small memory model and responder.
// Expected transfers are queued when memory contents are planted and are checked on each grant.
// Grant and rvalid timing are set per scenario.
module tb_rvecc_scrubber;
  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 2;
  localparam int INTERVAL = 2;

  logic              clk = 1'b0;
  logic              rst_l;
  logic              scrub_en;
  logic              cnt_clr;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [38:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [38:0]       mem_rdata;
  logic [15:0]       sec_cnt;
  logic [15:0]       ded_cnt;
  logic              ded_valid;
  logic [ADDR_W-1:0] ded_addr;
  logic              pass_done;

  always #5 clk = ~clk;

  rvecc_scrubber #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INTERVAL(INTERVAL)) dut (
    .clk(clk), .rst_l(rst_l), .scrub_en(scrub_en), .cnt_clr(cnt_clr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .ded_valid(ded_valid), .ded_addr(ded_addr),
    .pass_done(pass_done)
  );

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [38:0]       wdata;
    logic [7:0]        gap;
  } xact_t;

  int                n_cmp = 0;
  int                n_err = 0;
  int                cyc = 0;
  logic [5:0]        pos_tbl [32];
  logic [38:0]       mem   [DEPTH];
  logic [31:0]       orig  [DEPTH];
  int                kind  [DEPTH];
  xact_t             exp_q [$];
  logic [ADDR_W-1:0] ded_q [$];
  int                exp_sec = 0;
  int                exp_ded = 0;
  int                pd_cnt = 0;
  int                rd_grants = 0;
  int                rv_lat = 1;
  int                rv_cnt = 0;
  logic [ADDR_W-1:0] rd_addr = '0;
  int                last_rd = 0;
  int                hold_left = 0;
  logic              hold_active = 1'b0;
  logic [ADDR_W-1:0] cap_addr = '0;
  logic [38:0]       cap_wdata = '0;
  int                clr_addr = -1;
  logic              clr_pend = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Check bits as the XOR of the Hamming positions of all set data bits.
  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [5:0] s;
    s = '0;
    for (int i = 0; i < 32; i++) if (d[i]) s = s ^ pos_tbl[i];
    return {^{s, d}, s, d};
  endfunction

  task automatic set_word(input int a, input logic [31:0] d, input logic [38:0] flips);
    mem[a]  = enc(d) ^ flips;
    orig[a] = d;
    kind[a] = $countones(flips);
  endtask

  // Queue one pass worth of expected transfers; hold is the grant delay at hold_a.
  task automatic plan_pass(input int hold_a, input int hold);
    int extra;
    extra = -1;
    for (int a = 0; a < DEPTH; a++) begin
      exp_q.push_back('{we: 1'b0, addr: ADDR_W'(a), wdata: '0,
                        gap: (extra < 0) ? 8'd0 : 8'(6 + extra)});
      extra = 0;
      if (kind[a] == 1) begin
        exp_q.push_back('{we: 1'b1, addr: ADDR_W'(a), wdata: enc(orig[a]), gap: 8'd0});
        if (exp_sec < 16'hFFFF) exp_sec++;
        kind[a] = 0;
        extra = 1 + ((a == hold_a) ? hold : 0);
      end else if (kind[a] == 2) begin
        if (exp_ded < 16'hFFFF) exp_ded++;
        ded_q.push_back(ADDR_W'(a));
      end
    end
  endtask

  task automatic run_pass(input string tag);
    int pd0;
    int t;
    pd0 = pd_cnt;
    t = 0;
    scrub_en = 1'b1;
    while (pd_cnt == pd0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_pass_seen"}, 64'(pd_cnt != pd0), 64'd1);
    scrub_en = 1'b0;
    repeat (4) @(negedge clk);
    chk({tag, "_pass_once"}, 64'(pd_cnt - pd0), 64'd1);
    chk({tag, "_q_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_ded_left"}, 64'(ded_q.size()), 64'd0);
    chk({tag, "_sec_cnt"}, 64'(sec_cnt), 64'(exp_sec));
    chk({tag, "_ded_cnt"}, 64'(ded_cnt), 64'(exp_ded));
  endtask

  // Memory responder: grant, read data return, write-stability checks, scoreboard.
  initial begin
    xact_t e;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    cnt_clr = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      cnt_clr = 1'b0;
      if (clr_pend) begin
        cnt_clr = 1'b1;
        clr_pend = 1'b0;
      end
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = mem[rd_addr];
          if (int'(rd_addr) == clr_addr) clr_pend = 1'b1;
        end
      end
      if (hold_active) begin
        chk("hold_req", 64'(mem_req), 64'd1);
        chk("hold_we", 64'(mem_we), 64'd1);
        chk("hold_addr", 64'(mem_addr), 64'(cap_addr));
        chk("hold_wdata", 64'(mem_wdata), 64'(cap_wdata));
      end
      if (mem_req === 1'b1) begin
        chk("one_outstanding", 64'(rv_cnt), 64'd0);
        if (mem_we && hold_left > 0) begin
          if (!hold_active) begin
            hold_active = 1'b1;
            cap_addr = mem_addr;
            cap_wdata = mem_wdata;
          end
          hold_left--;
        end else begin
          hold_active = 1'b0;
          mem_gnt = 1'b1;
          if (exp_q.size() == 0) begin
            chk("unexpected_xfer", {mem_we, 39'(mem_addr)}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("xfer_we", 64'(mem_we), 64'(e.we));
            chk("xfer_addr", 64'(mem_addr), 64'(e.addr));
            if (e.we) chk("xfer_wdata", 64'(mem_wdata), 64'(e.wdata));
            if (!mem_we && e.gap != 8'd0) chk("rd_gap", 64'(cyc - last_rd), 64'(e.gap));
          end
          if (!mem_we) begin
            rv_cnt = rv_lat;
            rd_addr = mem_addr;
            last_rd = cyc;
            rd_grants++;
          end else begin
            mem[mem_addr] = mem_wdata;
          end
        end
      end else begin
        hold_active = 1'b0;
      end
    end
  end

  // Event monitors for pass_done and ded_valid pulses.
  always @(negedge clk) begin
    if (pass_done === 1'b1) begin
      pd_cnt++;
      chk("pass_done_addr", 64'(mem_addr), 64'(DEPTH - 1));
      chk("pass_done_q_empty", 64'(exp_q.size()), 64'd0);
    end
    if (ded_valid === 1'b1) begin
      if (ded_q.size() == 0) chk("unexpected_ded", 64'(ded_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("ded_addr_pulse", 64'(ded_addr), 64'(ded_q.pop_front()));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected summary");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    p = 3;
    for (int i = 0; i < 32; i++) begin
      while ((p & (p - 1)) == 0) p++;
      pos_tbl[i] = 6'(p);
      p++;
    end
    for (int a = 0; a < DEPTH; a++) set_word(a, 32'h1357_0000 + 32'(a) * 32'h0101_0101, '0);

    rst_l = 1'b0;
    scrub_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_sec_cnt", 64'(sec_cnt), 64'd0);
    chk("rst_ded_cnt", 64'(ded_cnt), 64'd0);
    chk("rst_ded_valid", 64'(ded_valid), 64'd0);
    chk("rst_ded_addr", 64'(ded_addr), 64'd0);
    chk("rst_pass_done", 64'(pass_done), 64'd0);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);

    // Disabled scrubber stays parked.
    repeat (10) @(negedge clk);
    chk("parked_no_req", 64'(rd_grants), 64'd0);

    // Clean pass.
    plan_pass(-1, 0);
    run_pass("t1_clean");

    // Single data-bit error at addr 2.
    set_word(2, 32'hDEADBEEF, 39'(1) << 5);
    plan_pass(-1, 0);
    run_pass("t2_sec");
    chk("t2_mem_fixed", 64'(mem[2]), 64'(enc(32'hDEADBEEF)));

    // Double error at addr 1: bits 0 and 38.
    set_word(1, 32'hCAFE_F00D, (39'(1) << 38) | 39'(1));
    plan_pass(-1, 0);
    run_pass("t3_ded");
    chk("t3_ded_addr_hold", 64'(ded_addr), 64'd1);
    chk("t3_mem_untouched", 64'(mem[1]), 64'(enc(32'hCAFE_F00D) ^ ((39'(1) << 38) | 39'(1))));
    set_word(1, 32'hCAFE_F00D, '0);

    // Check-bit error at addr 0 with the write grant held off 5 cycles.
    set_word(0, 32'h0F0F_A5A5, 39'(1) << 35);
    hold_left = 5;
    plan_pass(0, 5);
    run_pass("t4_hold");
    chk("t4_hold_used", 64'(hold_left), 64'd0);

    // Saturation: start one below the ceiling, then two more single errors.
    force dut.sec_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.sec_cnt_q;
    exp_sec = 16'hFFFE;
    chk("t5_preload", 64'(sec_cnt), 64'hFFFE);
    set_word(0, 32'h0000_0001, 39'(1) << 31);
    set_word(3, 32'h8000_0000, 39'(1) << 12);
    plan_pass(-1, 0);
    run_pass("t5_sat");

    // Clear in the same cycle as an increment, then a later double error.
    set_word(1, 32'h7777_1234, 39'(1) << 20);
    set_word(2, 32'h2468_ACE0, (39'(1) << 3) | (39'(1) << 30));
    clr_addr = 1;
    plan_pass(-1, 0);
    exp_sec = 0;
    exp_ded = 1;
    run_pass("t5_clr");
    clr_addr = -1;
    set_word(2, 32'h2468_ACE0, '0);

    // Reset while waiting for read data.
    rv_lat = 4;
    exp_q.push_back('{we: 1'b0, addr: '0, wdata: '0, gap: 8'd0});
    begin
      int g0;
      int t;
      g0 = rd_grants;
      t = 0;
      scrub_en = 1'b1;
      while (rd_grants == g0 && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("t6_read_granted", 64'(rd_grants - g0), 64'd1);
    end
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    chk("t6_rst_mem_req", 64'(mem_req), 64'd0);
    chk("t6_rst_mem_we", 64'(mem_we), 64'd0);
    chk("t6_rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("t6_rst_sec_cnt", 64'(sec_cnt), 64'd0);
    chk("t6_rst_ded_cnt", 64'(ded_cnt), 64'd0);
    chk("t6_rst_ded_addr", 64'(ded_addr), 64'd0);
    chk("t6_rst_ded_valid", 64'(ded_valid), 64'd0);
    chk("t6_rst_pass_done", 64'(pass_done), 64'd0);
    exp_sec = 0;
    exp_ded = 0;
    plan_pass(-1, 0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    rv_lat = 1;
    run_pass("t6_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
